rf_write_arbiter: RTL and testbench

- Shares the single register-file write port between the pipeline write-back stage and a long-latency unit (mul/div, late load return).
- Write-back has priority. Long-latency results are queued in a small FIFO and drained into idle write-port cycles.
- Queued entries made stale by a younger write-back write are killed.
- A starvation counter forces a one-cycle pipeline stall so the queue always drains.

---
 rtl/rf_write_arbiter.sv | 135 +++++++++++++
 tb/tb_rf_write_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: write-back has priority, long-latency results
// wait in a small FIFO, stale queued entries are killed, and starvation forces a stall.
module rf_write_arbiter #(
   parameter int DEPTH      = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wb_we,
   input  logic [4:0]  wb_addr,
   input  logic [31:0] wb_data,
   input  logic        lu_valid,
   input  logic [4:0]  lu_addr,
   input  logic [31:0] lu_data,
   output logic        lu_ready,
   output logic        rf_we,
   output logic [4:0]  rf_addr,
   output logic [31:0] rf_data,
   output logic        stall_out,
   output logic [31:0] pend_mask
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam int SW = $clog2(STARVE_MAX + 1);

   logic [4:0]       addr_q [DEPTH];
   logic [31:0]      data_q [DEPTH];
   logic [DEPTH-1:0] vld_q, vld_d;
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [SW-1:0]    starve_q, starve_d;
   logic             stall_q, stall_d;
   logic             rf_we_q, rf_we_d;
   logic [4:0]       rf_addr_q, rf_addr_d;
   logic [31:0]      rf_data_q, rf_data_d;

   logic full, empty, wb_req, push, pop, head_vld;

   always_comb begin
      full     = (cnt_q == CW'(DEPTH));
      empty    = (cnt_q == '0);
      wb_req   = wb_we && (wb_addr != 5'd0) && !stall_q;
      push     = lu_valid && !full && (lu_addr != 5'd0);
      pop      = !wb_req && !empty;
      head_vld = vld_q[rd_ptr_q];
      cnt_d    = cnt_q + CW'(push) - CW'(pop);
   end

   // Kill matching entries first; a same-cycle push to the killed register lands invalid.
   always_comb begin
      vld_d = vld_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (wb_req && (addr_q[i] == wb_addr)) vld_d[i] = 1'b0;
      end
      if (pop)  vld_d[rd_ptr_q] = 1'b0;
      if (push) vld_d[wr_ptr_q] = !(wb_req && (lu_addr == wb_addr));
   end

   always_comb begin
      rf_we_d   = 1'b0;
      rf_addr_d = rf_addr_q;
      rf_data_d = rf_data_q;
      if (wb_req) begin
         rf_we_d   = 1'b1;
         rf_addr_d = wb_addr;
         rf_data_d = wb_data;
      end else if (pop && head_vld) begin
         rf_we_d   = 1'b1;
         rf_addr_d = addr_q[rd_ptr_q];
         rf_data_d = data_q[rd_ptr_q];
      end
   end

   always_comb begin
      starve_d = starve_q;
      stall_d  = 1'b0;
      if (empty || pop) begin
         starve_d = '0;
      end else if (wb_req) begin
         if (starve_q + SW'(1) == SW'(STARVE_MAX)) begin
            starve_d = '0;
            stall_d  = 1'b1;
         end else begin
            starve_d = starve_q + SW'(1);
         end
      end
   end

   always_comb begin
      pend_mask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (vld_q[i]) pend_mask[addr_q[i]] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
         vld_q     <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
         starve_q  <= '0;
         stall_q   <= 1'b0;
         rf_we_q   <= 1'b0;
         rf_addr_q <= '0;
         rf_data_q <= '0;
      end else begin
         if (push) begin
            addr_q[wr_ptr_q] <= lu_addr;
            data_q[wr_ptr_q] <= lu_data;
            wr_ptr_q         <= wr_ptr_q + PW'(1);
         end
         if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
         vld_q     <= vld_d;
         cnt_q     <= cnt_d;
         starve_q  <= starve_d;
         stall_q   <= stall_d;
         rf_we_q   <= rf_we_d;
         rf_addr_q <= rf_addr_d;
         rf_data_q <= rf_data_d;
      end
   end

   assign lu_ready  = !full;
   assign rf_we     = rf_we_q;
   assign rf_addr   = rf_addr_q;
   assign rf_data   = rf_data_q;
   assign stall_out = stall_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: cycle model of the arbitration rules feeding a write
// scoreboard, plus directed checks at the interesting cycles.
module tb_rf_write_arbiter;

   localparam int DEPTH      = 2;
   localparam int STARVE_MAX = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wb_we, lu_valid;
   logic [4:0]  wb_addr, lu_addr;
   logic [31:0] wb_data, lu_data;
   logic        lu_ready, rf_we, stall_out;
   logic [4:0]  rf_addr;
   logic [31:0] rf_data, pend_mask;

   rf_write_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .rst_n(rst_n),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
      .lu_valid(lu_valid), .lu_addr(lu_addr), .lu_data(lu_data),
      .lu_ready(lu_ready), .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
      .stall_out(stall_out), .pend_mask(pend_mask)
   );

   always #5 clk = ~clk;

   typedef struct {logic [4:0] a; logic [31:0] d; logic v;} ent_t;
   typedef struct {logic [4:0] a; logic [31:0] d;} wr_t;

   ent_t        m_q[$];
   wr_t         exp_q[$];
   logic        m_stall, m_we;
   int          m_cnt;
   logic [4:0]  m_addr;
   logic [31:0] m_data;
   int          n_chk = 0, n_err = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      exp_q.delete();
      m_stall = 1'b0;
      m_we    = 1'b0;
      m_cnt   = 0;
      m_addr  = '0;
      m_data  = '0;
   endtask

   task automatic idle_inputs();
      wb_we = 0; wb_addr = 0; wb_data = 0;
      lu_valid = 0; lu_addr = 0; lu_data = 0;
   endtask

   // Called at posedge+1 with inputs already driven; advances one cycle.
   task automatic step();
      logic [31:0] pend;
      logic        wreq, acc, nonempty, popped, nxt_stall;
      ent_t        h;
      wr_t         w;
      pend = '0;
      foreach (m_q[i]) if (m_q[i].v) pend[m_q[i].a] = 1'b1;
      chk("lu_ready", 32'(lu_ready), 32'(m_q.size() < DEPTH));
      chk("pend_mask", pend_mask, pend);
      chk("stall_out", 32'(stall_out), 32'(m_stall));
      wreq     = wb_we && (wb_addr != 0) && !m_stall;
      acc      = lu_valid && (m_q.size() < DEPTH) && (lu_addr != 0);
      nonempty = (m_q.size() != 0);
      popped   = 1'b0;
      m_we     = 1'b0;
      if (wreq) begin
         m_we = 1'b1; m_addr = wb_addr; m_data = wb_data;
         foreach (m_q[i]) if (m_q[i].a == wb_addr) m_q[i].v = 1'b0;
      end else if (nonempty) begin
         h = m_q.pop_front();
         popped = 1'b1;
         if (h.v) begin m_we = 1'b1; m_addr = h.a; m_data = h.d; end
      end
      if (m_we) exp_q.push_back('{m_addr, m_data});
      if (acc) m_q.push_back('{lu_addr, lu_data, !(wreq && (lu_addr == wb_addr))});
      nxt_stall = 1'b0;
      if (!nonempty || popped) m_cnt = 0;
      else if (wreq) begin
         m_cnt++;
         if (m_cnt == STARVE_MAX) begin nxt_stall = 1'b1; m_cnt = 0; end
      end
      @(posedge clk); #1;
      m_stall = nxt_stall;
      chk("rf_we", 32'(rf_we), 32'(m_we));
      if (rf_we) begin
         if (exp_q.size() == 0) chk("sb_underflow", 32'(1), 32'(0));
         else begin
            w = exp_q.pop_front();
            chk("rf_addr", 32'(rf_addr), 32'(w.a));
            chk("rf_data", rf_data, w.d);
         end
      end else begin
         chk("rf_addr_hold", 32'(rf_addr), 32'(m_addr));
         chk("rf_data_hold", rf_data, m_data);
      end
   endtask

   initial begin
      int first_stall, second_stall, at3, at4, n;
      rst_n = 1'b0;
      idle_inputs();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rf_we", 32'(rf_we), 32'(0));
      chk("rst_stall", 32'(stall_out), 32'(0));
      chk("rst_lu_ready", 32'(lu_ready), 32'(1));
      chk("rst_pend", pend_mask, 32'(0));
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      step();

      // simple write-back
      wb_we = 1; wb_addr = 5; wb_data = 32'hDEADBEEF;
      step();
      idle_inputs();
      chk("t1_we", 32'(rf_we), 32'(1));
      chk("t1_addr", 32'(rf_addr), 32'(5));
      chk("t1_data", rf_data, 32'hDEADBEEF);
      chk("t1_pend", pend_mask, 32'(0));
      step();

      // single LU result drains on an idle cycle
      lu_valid = 1; lu_addr = 7; lu_data = 32'h11;
      step();
      idle_inputs();
      chk("t2_pend7_set", 32'(pend_mask[7]), 32'(1));
      chk("t2_no_write_yet", 32'(rf_we), 32'(0));
      step();
      chk("t2_we", 32'(rf_we), 32'(1));
      chk("t2_addr", 32'(rf_addr), 32'(7));
      chk("t2_data", rf_data, 32'h11);
      chk("t2_pend7_clr", 32'(pend_mask[7]), 32'(0));
      step();

      // starvation: WB busy every cycle, two queued entries
      first_stall = -1; second_stall = -1; at3 = -1; at4 = -1;
      for (int i = 0; i < 14; i++) begin
         wb_we = 1; wb_addr = 5'(16 + i); wb_data = 32'h1000 + i;
         lu_valid = (i < 2); lu_addr = (i == 0) ? 5'd3 : 5'd4; lu_data = 32'h300 + i;
         step();
         if (i == 1) chk("t3_full", 32'(lu_ready), 32'(0));
         if (stall_out) begin
            if (first_stall < 0) first_stall = i;
            else if (second_stall < 0) second_stall = i;
         end
         if (rf_we && rf_addr == 3) at3 = i;
         if (rf_we && rf_addr == 4) at4 = i;
      end
      idle_inputs();
      chk("t3_stall1", 32'(first_stall), 32'(4));
      chk("t3_stall2", 32'(second_stall), 32'(9));
      chk("t3_drain3", 32'(at3), 32'(5));
      chk("t3_drain4", 32'(at4), 32'(10));
      chk("t3_empty", pend_mask, 32'(0));
      step();

      // kill: queued r9 overwritten by WB before drain
      wb_we = 1; wb_addr = 10; wb_data = 32'h1010;
      lu_valid = 1; lu_addr = 9; lu_data = 32'h99;
      step();
      chk("t4_pend9_set", 32'(pend_mask[9]), 32'(1));
      lu_valid = 0; wb_addr = 9; wb_data = 32'hAAAA;
      step();
      idle_inputs();
      chk("t4_pend9_clr", 32'(pend_mask[9]), 32'(0));
      chk("t4_addr", 32'(rf_addr), 32'(9));
      chk("t4_data", rf_data, 32'hAAAA);
      step();
      chk("t4_bubble", 32'(rf_we), 32'(0));
      chk("t4_ready", 32'(lu_ready), 32'(1));
      step();

      // register 0 from both sides
      wb_we = 1; wb_addr = 0; wb_data = 32'h5555;
      lu_valid = 1; lu_addr = 0; lu_data = 32'h6666;
      step();
      idle_inputs();
      chk("t5_we", 32'(rf_we), 32'(0));
      chk("t5_ready", 32'(lu_ready), 32'(1));
      chk("t5_pend", pend_mask, 32'(0));
      step();

      // random traffic on a small register range to provoke kills
      for (int i = 0; i < 300; i++) begin
         wb_we = 1'($urandom_range(0, 1)); wb_addr = 5'($urandom_range(0, 7));
         wb_data = $urandom;
         lu_valid = 1'($urandom_range(0, 1)); lu_addr = 5'($urandom_range(0, 7));
         lu_data = $urandom;
         step();
      end
      idle_inputs();
      repeat (4) step();

      // async reset while full and stalling
      n = 0;
      while (!stall_out && n < 20) begin
         wb_we = 1; wb_addr = 5'(20 + (n % 8)); wb_data = 32'h2000 + n;
         lu_valid = 1; lu_addr = 5'(1 + (n % 2)); lu_data = 32'h700 + n;
         step();
         n++;
      end
      chk("t6_reached_stall", 32'(stall_out), 32'(1));
      chk("t6_full", 32'(lu_ready), 32'(0));
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rf_we", 32'(rf_we), 32'(0));
      chk("t6_rf_addr", 32'(rf_addr), 32'(0));
      chk("t6_rf_data", rf_data, 32'(0));
      chk("t6_stall", 32'(stall_out), 32'(0));
      chk("t6_pend", pend_mask, 32'(0));
      chk("t6_ready", 32'(lu_ready), 32'(1));
      idle_inputs();
      model_reset();
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      chk("t6_post_we", 32'(rf_we), 32'(0));
      repeat (5) step();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
